// File: rtl/key_access_arbiter.sv
// Round-robin gatekeeper for the secret key store: authorises requesters, releases the key for one cycle.
// Optional audit outputs (audit_id, audit_grants) are enabled by defining KEY_ACCESS_AUDIT_EN.
module key_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_W       = 32,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_auth,
  output logic                       key_rd_en,
  input  logic [KEY_W-1:0]           key_in,
  output logic [KEY_W-1:0]           key_out,
  output logic                       key_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         deny,
`ifdef KEY_ACCESS_AUDIT_EN
  output logic [$clog2(NUM_REQ)-1:0] audit_id,
  output logic [15:0]                audit_grants,
`endif
  output logic                       locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, READ, WAIT, RELEASE, LOCKED} state_t;

  state_t               state_r;
  logic [IW-1:0]        rr_ptr_r;
  logic [IW-1:0]        winner_r;
  logic [3:0]           fail_cnt_r;
  logic [TW-1:0]        lock_timer_r;
  logic                 key_rd_en_r;
  logic [KEY_W-1:0]     key_out_r;
  logic                 key_valid_r;
  logic [NUM_REQ-1:0]   grant_r;
  logic [NUM_REQ-1:0]   deny_r;
  logic                 locked_r;
  logic                 win_found_s;
  logic [IW-1:0]        win_idx_s;
  logic [IW-1:0]        rr_next_s;

  // Scan downward so the requester closest to the pointer is the last (winning) assignment.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NUM_REQ;
      if (r[k]) begin
        res = {1'b1, IW'(k)};
      end
    end
    return res;
  endfunction

  // Round-robin winner selection and next pointer value.
  always_comb begin
    {win_found_s, win_idx_s} = rr_pick(req, rr_ptr_r);
    if (win_idx_s == IW'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = win_idx_s + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  // Transaction sequencer, fail/lockout tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      winner_r     <= '0;
      fail_cnt_r   <= 4'd0;
      lock_timer_r <= '0;
      key_rd_en_r  <= 1'b0;
      key_out_r    <= '0;
      key_valid_r  <= 1'b0;
      grant_r      <= '0;
      deny_r       <= '0;
      locked_r     <= 1'b0;
    end else begin
      key_rd_en_r <= 1'b0;
      deny_r      <= '0;
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            rr_ptr_r <= rr_next_s;
            winner_r <= win_idx_s;
            if (req_auth[win_idx_s]) begin
              key_rd_en_r <= 1'b1;
              state_r     <= READ;
            end else begin
              deny_r     <= ONE_HOT0 << win_idx_s;
              fail_cnt_r <= fail_cnt_r + 4'd1;
              if ((fail_cnt_r + 4'd1) >= 4'(MAX_FAIL)) begin
                locked_r     <= 1'b1;
                lock_timer_r <= '0;
                state_r      <= LOCKED;
              end
            end
          end
        end
        READ: begin
          state_r <= req[winner_r] ? WAIT : IDLE;
        end
        WAIT: begin
          if (req[winner_r]) begin
            key_out_r   <= key_in;
            key_valid_r <= 1'b1;
            grant_r     <= ONE_HOT0 << winner_r;
            state_r     <= RELEASE;
          end else begin
            state_r <= IDLE;
          end
        end
        RELEASE: begin
          key_out_r   <= '0;
          key_valid_r <= 1'b0;
          grant_r     <= '0;
          fail_cnt_r  <= 4'd0;
          state_r     <= IDLE;
        end
        LOCKED: begin
          if (lock_timer_r == TW'(LOCK_CYCLES - 1)) begin
            locked_r   <= 1'b0;
            fail_cnt_r <= 4'd0;
            state_r    <= IDLE;
          end else begin
            lock_timer_r <= lock_timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          key_out_r   <= '0;
          key_valid_r <= 1'b0;
          grant_r     <= '0;
          locked_r    <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef KEY_ACCESS_AUDIT_EN
  logic [IW-1:0] audit_id_r;
  logic [15:0]   audit_grants_r;

  // Audit trail tracks the same edges that raise grant or deny.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audit_id_r     <= '0;
      audit_grants_r <= 16'd0;
    end else if (state_r == IDLE && win_found_s && !req_auth[win_idx_s]) begin
      audit_id_r <= win_idx_s;
    end else if (state_r == WAIT && req[winner_r]) begin
      audit_id_r <= winner_r;
      if (audit_grants_r != 16'hFFFF) begin
        audit_grants_r <= audit_grants_r + 16'd1;
      end
    end
  end

  assign audit_id     = audit_id_r;
  assign audit_grants = audit_grants_r;
`endif

  assign key_rd_en = key_rd_en_r;
  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  assign grant     = grant_r;
  assign deny      = deny_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_key_access_arbiter.sv
// Directed bench for key_access_arbiter: release timing, round-robin, lockout, abort and reset.
module tb_key_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_auth;
  logic        key_rd_en;
  logic [31:0] key_in;
  logic [31:0] key_out;
  logic        key_valid;
  logic [3:0]  grant;
  logic [3:0]  deny;
  logic        locked;
`ifdef KEY_ACCESS_AUDIT_EN
  logic [1:0]  audit_id;
  logic [15:0] audit_grants;
`endif

  int checks = 0;
  int errors = 0;

  key_access_arbiter #(.NUM_REQ(4), .KEY_W(32), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_auth(req_auth),
    .key_rd_en(key_rd_en), .key_in(key_in), .key_out(key_out),
    .key_valid(key_valid), .grant(grant), .deny(deny),
`ifdef KEY_ACCESS_AUDIT_EN
    .audit_id(audit_id), .audit_grants(audit_grants),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; req_auth = 4'b0000; key_in = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_key_out", key_out, 32'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_grant", grant, 4'b0000);
    check("rst_deny", deny, 4'b0000);
    check("rst_locked", locked, 1'b0);
    check("rst_rd_en", key_rd_en, 1'b0);
    rst = 1'b0;
    tick(1);

    // 1: single authorised request
    req = 4'b0001; req_auth = 4'b0001; key_in = 32'h12345678;
    tick(1);
    check("t1_rd_en", key_rd_en, 1'b1);
    check("t1_valid_early", key_valid, 1'b0);
    tick(1);
    check("t1_rd_en_off", key_rd_en, 1'b0);
    check("t1_key_wait", key_out, 32'h0);
    tick(1);
    check("t1_valid", key_valid, 1'b1);
    check("t1_grant", grant, 4'b0001);
    check("t1_key", key_out, 32'h12345678);
    req = 4'b0000;
    tick(1);
    check("t1_valid_off", key_valid, 1'b0);
    check("t1_key_zero", key_out, 32'h0);
    check("t1_grant_off", grant, 4'b0000);

    // 2: two held requesters served in turn, pointer wraps to 0
    req = 4'b1010; req_auth = 4'b1010; key_in = 32'hCAFE0001;
    tick(3);
    check("t2_grant_a", grant, 4'b0010);
    check("t2_key_a", key_out, 32'hCAFE0001);
    key_in = 32'hCAFE0003;
    tick(4);
    check("t2_grant_b", grant, 4'b1000);
    check("t2_key_b", key_out, 32'hCAFE0003);
    req = 4'b0000;
    tick(1);
    req = 4'b0011; req_auth = 4'b0011; key_in = 32'hA5A50F0F;
    tick(3);
    check("t2_wrap_grant", grant, 4'b0001);
    check("t2_wrap_key", key_out, 32'hA5A50F0F);
    req = 4'b0000;
    tick(1);

    // 4: abort in WAIT (pointer=1, only req0 -> winner 0)
    req = 4'b0001; req_auth = 4'b0001; key_in = 32'hFFFFFFFF;
    tick(1);
    check("t4_rd_en", key_rd_en, 1'b1);
    tick(1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_no_valid", key_valid, 1'b0);
      check("t4_key_zero", key_out, 32'h0);
      check("t4_no_grant", grant, 4'b0000);
      check("t4_no_deny", deny, 4'b0000);
    end
    req = 4'b0010; req_auth = 4'b0010; key_in = 32'h00C0FFEE;
    tick(3);
    check("t4_after_grant", grant, 4'b0010);
    req = 4'b0000;
    tick(1);

    // 3: three denials trigger 16-cycle lockout (pointer=2 -> winner 2)
    req_auth = 4'b0000;
    for (int n = 1; n <= 2; n++) begin
      req = 4'b0100;
      tick(1);
      check("t3_deny", deny, 4'b0100);
      check("t3_not_locked", locked, 1'b0);
      req = 4'b0000;
      tick(1);
      check("t3_deny_pulse", deny, 4'b0000);
    end
    req = 4'b0100;
    tick(1);
    check("t3_deny3", deny, 4'b0100);
    check("t3_locked", locked, 1'b1);
    req_auth = 4'b0100;
    key_in = 32'h5EC0E7AA;
    for (int i = 1; i < 16; i++) begin
      tick(1);
      check("t3_lock_held", locked, 1'b1);
      check("t3_lock_nodeny", deny, 4'b0000);
      check("t3_lock_nord", key_rd_en, 1'b0);
    end
    tick(1);
    check("t3_unlocked", locked, 1'b0);
    tick(1);
    check("t3_rd_after", key_rd_en, 1'b1);
    tick(2);
    check("t3_grant_after", grant, 4'b0100);
    check("t3_key_after", key_out, 32'h5EC0E7AA);
    req = 4'b0000;
    tick(1);

    // 5: reset during RELEASE (pointer=3, winner 0)
    req = 4'b0001; req_auth = 4'b0001; key_in = 32'hDEADBEEF;
    tick(3);
    check("t5_valid", key_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_key", key_out, 32'h0);
    check("t5_rst_valid", key_valid, 1'b0);
    check("t5_rst_grant", grant, 4'b0000);
    req = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(1);
    req = 4'b0011; req_auth = 4'b0011; key_in = 32'h0BADF00D;
    tick(3);
    check("t5_rr_reset_grant", grant, 4'b0001);
    check("t5_key", key_out, 32'h0BADF00D);
    req = 4'b0000;
    tick(1);

`ifdef KEY_ACCESS_AUDIT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_audit_rst", audit_grants, 16'd0);
    req = 4'b0100; req_auth = 4'b0100;
    tick(7);
    check("t6_grant2", grant, 4'b0100);
    check("t6_audit_id", audit_id, 2'd2);
    check("t6_audit_grants", audit_grants, 16'd2);
    req = 4'b0000;
    tick(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
